ws281x_rx: RTL and testbench
============================

// Module: ws281x_rx
// PURPOSE
//  WS281x single-wire receiver/decoder: the receive-side counterpart of the ws281x transmit path.
//  Samples a WS281x serial line, classifies each high pulse as bit-0/bit-1 by width, assembles
//  24-bit GRB pixels MSB-first and buffers them in a FIFO for register-bus readout.
//  Used for ws281x loopback self-test and for capturing an upstream LED chain.
// PARAMETERS
//  FIFO_D   8   pixel FIFO depth (entries of 24 bits)
//  FLT_N    3   glitch-filter stability length in mclk cycles (used only with the filter macro)
// PORTS
//  mclk              in   1   system clock
//  h_reset_n         in   1   asynchronous active-low reset
//  cfg_enb           in   1   receiver enable; 0 = idle and resynchronise
//  cfg_reset_period  in   16  line-low cycles (mclk) that mark a frame reset/latch
//  cfg_bit_thresh    in   10  high-pulse width (mclk); width > thresh = bit-1, else bit-0
//  rx_din            in   1   asynchronous serial line input
//  rx_rd             in   1   FIFO pop; ignored when empty
//  rx_data           out  24  FIFO head pixel {G,R,B}
//  rx_dval           out  1   FIFO not empty
//  rx_full           out  1   FIFO full
//  rx_frame_done     out  1   1-cycle pulse at end of a frame holding >=1 complete pixel
//  rx_ovf            out  1   sticky: a pixel was dropped because the FIFO was full
//  rx_err            out  1   sticky: partial pixel at reset, or high pulse >= 1023 cycles
//  rx_clr            in   1   clears rx_ovf and rx_err (wins over a same-cycle set)
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, state S_SYNC, counters/shift register/bit count 0.
//  - rx_din passes a 2-flop synchroniser; edges are detected on the synchronised value (din_s).
//  - FSM: S_SYNC: wait for din_s low for cfg_reset_period consecutive cycles -> S_LOW (never
//    decode from mid-frame). S_LOW: low_cnt counts; rising edge -> S_HIGH, high_cnt=1;
//    low_cnt reaching cfg_reset_period ends the frame: bit_cnt!=0 -> discard partial, set rx_err;
//    pulse rx_frame_done if >=1 pixel decoded since last frame end; stay S_LOW.
//    S_HIGH: high_cnt counts; falling edge -> classify, shift bit in, bit_cnt++, low_cnt=1, S_LOW;
//    high_cnt saturating at 1023 -> set rx_err, clear shift/bit_cnt, -> S_SYNC.
//  - Counters saturate (low 16 bits, high 10 bits); no wrap-around.
//  - 24th bit: FIFO write asserted in the falling-edge-detect cycle; rx_dval high next cycle.
//    FIFO full at that write -> pixel dropped, rx_ovf set, FIFO untouched; bit_cnt returns to 0.
//  - Simultaneous rx_rd and write on full FIFO: write still dropped (full sampled pre-pop).
//  - cfg_enb=0: FSM forced to S_SYNC, shift/bit_cnt cleared next cycle; FIFO contents and
//    stickies kept. cfg_reset_period=0 treated as 1.
//  - Latency rx_din rising edge -> S_HIGH: 3 cycles (sync 2 + edge detect 1).
// CONFIGURATION
//  WS281X_RX_GLITCH_FILTER_EN defined: din_s passes a filter that only changes its output after
//   FLT_N consecutive equal samples; pulses shorter than FLT_N cycles ignored; latency +FLT_N.
//  Undefined: filter absent, din_s used directly, latency as above.
// STRUCTURE
//  - Shared package ws281x_pkg: state enum (S_SYNC,S_LOW,S_HIGH), PIXEL_W=24, HCNT_W=10,
//    LCNT_W=16, HCNT_MAX=10'h3FF.
//  - Sub-module: existing sync_fifo (W=24, D=FIFO_D) for pixel buffering; decoder FSM inline.
// TESTING
//  - Reset period 100, thresh 40: after 100 low, pulses 60/20 for 0xFF00AA bits, then 100 low
//    -> rx_data=0xFF00AA, rx_dval=1, one rx_frame_done pulse, rx_err=0.
//  - Frame starting with rx_din already toggling (no prior low 100) -> nothing decoded until
//    first 100-cycle low; subsequent pixel 0x123456 captured correctly.
//  - 9 pixels into depth 8, no rx_rd -> 8 stored, 9th dropped, rx_ovf=1; rx_clr -> rx_ovf=0.
//  - 12 bits then 100 low -> no FIFO write, rx_err=1, no rx_frame_done; next full pixel ok.
//  - High held 1100 cycles -> rx_err=1, state S_SYNC; cfg_enb drop mid-pixel -> bit_cnt=0.
//  - With WS281X_RX_GLITCH_FILTER_EN, FLT_N=3: 2-cycle spikes during low gaps -> no bits
//    added; pixel 0xA5A5A5 decoded intact.

Source files
------------

// File: rtl/ws281x_pkg.sv
// Shared types and widths for the WS281x receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ws281x_pkg;

  localparam int PIXEL_W = 24;
  localparam int HCNT_W  = 10;
  localparam int LCNT_W  = 16;
  localparam int BCNT_W  = 5;

  localparam logic [HCNT_W-1:0] HCNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } rx_state_e;

endpackage

// File: rtl/ws281x_rx_if.sv
// Pixel readout port of the WS281x receiver (FIFO head, pop, status).
// Latency: rx_data/rx_dval reflect the FIFO head combinationally from registered state.
// Backpressure: the consumer pops with rx_rd; a full FIFO makes the decoder drop pixels.
interface ws281x_rx_if;
  import ws281x_pkg::*;

  logic               rx_rd;
  logic [PIXEL_W-1:0] rx_data;
  logic               rx_dval;
  logic               rx_full;

  modport master (output rx_rd, input rx_data, input rx_dval, input rx_full);
  modport slave  (input rx_rd, output rx_data, output rx_dval, output rx_full);

endinterface

// File: rtl/ws281x_rx_sync_fifo.sv
// Generic single-clock FIFO, arbitrary depth, head word visible on rd_dat.
// Latency: a write is visible (empty=0) the cycle after it is accepted.
// Backpressure: writes while full are ignored (full sampled before a same-cycle pop).
module sync_fifo #(
  parameter int W = 24,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(D);
  localparam logic [AW-1:0] LAST_PTR = AW'(D - 1);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_fire, rd_fire;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  // Head word forced to zero when empty so the port never shows stale or unset storage.
  assign rd_dat  = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer wrap and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_fire) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    if (wr_fire && !rd_fire)      cnt_d = cnt_q + 1'b1;
    else if (!wr_fire && rd_fire) cnt_d = cnt_q - 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; no reset needed since reads of unwritten entries are masked.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/ws281x_rx.sv
// WS281x single-wire receiver: classifies high pulses by width, packs 24-bit GRB pixels into a FIFO.
// Latency: rx_din rise -> S_HIGH 3 cycles (+FLT_N with WS281X_RX_GLITCH_FILTER_EN); 24th bit -> rx_dval +1.
// Backpressure: none on the line; a pixel completing into a full FIFO is dropped and rx_ovf is set.
module ws281x_rx
  import ws281x_pkg::*;
#(
  parameter int FIFO_D = 8,
  parameter int FLT_N  = 3
) (
  input  logic               mclk,
  input  logic               h_reset_n,
  input  logic               cfg_enb,
  input  logic [LCNT_W-1:0]  cfg_reset_period,
  input  logic [HCNT_W-1:0]  cfg_bit_thresh,
  input  logic               rx_din,
  input  logic               rx_clr,
  output logic               rx_frame_done,
  output logic               rx_ovf,
  output logic               rx_err,
  ws281x_rx_if.slave         bus
);

  rx_state_e            state_q, state_d;
  logic [LCNT_W-1:0]    low_cnt_q, low_cnt_d;
  logic [HCNT_W-1:0]    high_cnt_q, high_cnt_d;
  logic [PIXEL_W-2:0]   shift_q, shift_d;
  logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                 pix_seen_q, pix_seen_d;
  logic                 frame_done_q, frame_done_d;
  logic                 ovf_q, err_q;
  logic                 din_m_q, din_s_q, din_p_q;
  logic                 din_f;
  logic                 rise, fall;
  logic [LCNT_W-1:0]    rp, low_inc;
  logic                 low_reach, bit_val;
  logic                 wr_req, err_set, ovf_set;
  logic                 fifo_full, fifo_empty;
  logic [PIXEL_W-1:0]   wr_pix;

  // Two-flop synchroniser for the asynchronous line.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      din_m_q <= 1'b0;
      din_s_q <= 1'b0;
    end else begin
      din_m_q <= rx_din;
      din_s_q <= din_m_q;
    end
  end

`ifdef WS281X_RX_GLITCH_FILTER_EN
  localparam int FCW = (FLT_N > 1) ? $clog2(FLT_N) : 1;
  logic           flt_q, flt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  // Output follows the line only after FLT_N consecutive samples disagree with it.
  always_comb begin
    flt_d  = flt_q;
    fcnt_d = '0;
    if (din_s_q != flt_q) begin
      if (fcnt_q == FCW'(FLT_N - 1)) flt_d = din_s_q;
      else                           fcnt_d = fcnt_q + 1'b1;
    end
  end

  // Filter state.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      flt_q  <= 1'b0;
      fcnt_q <= '0;
    end else begin
      flt_q  <= flt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign din_f = flt_q;
`else
  // FLT_N has no effect without the filter.
  logic unused_flt_n;
  assign unused_flt_n = |FLT_N;
  assign din_f        = din_s_q;
`endif

  assign rise      = din_f && !din_p_q;
  assign fall      = !din_f && din_p_q;
  // A zero reset period would never be "reached"; treat it as one cycle.
  assign rp        = (cfg_reset_period == '0) ? LCNT_W'(1) : cfg_reset_period;
  assign low_inc   = (low_cnt_q == '1) ? low_cnt_q : low_cnt_q + 1'b1;
  // Fire only on the cycle the count arrives at the period, not while it stays there.
  assign low_reach = (low_inc == rp) && (low_cnt_q != rp);
  assign bit_val   = (high_cnt_q > cfg_bit_thresh);
  assign wr_pix    = {shift_q, bit_val};

  // Decoder next-state: frame sync, pulse measurement, bit assembly, FIFO write.
  always_comb begin
    state_d      = state_q;
    low_cnt_d    = low_cnt_q;
    high_cnt_d   = high_cnt_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    pix_seen_d   = pix_seen_q;
    frame_done_d = 1'b0;
    wr_req       = 1'b0;
    err_set      = 1'b0;
    ovf_set      = 1'b0;
    if (!cfg_enb) begin
      state_d    = S_SYNC;
      low_cnt_d  = '0;
      high_cnt_d = '0;
      shift_d    = '0;
      bit_cnt_d  = '0;
      pix_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        S_SYNC: begin
          // Never decode from mid-frame: require a full reset-length low first.
          if (din_f) begin
            low_cnt_d = '0;
          end else begin
            low_cnt_d = low_inc;
            if (low_inc >= rp) state_d = S_LOW;
          end
        end
        S_LOW: begin
          if (rise) begin
            state_d    = S_HIGH;
            high_cnt_d = HCNT_W'(1);
            low_cnt_d  = '0;
          end else begin
            low_cnt_d = low_inc;
            if (low_reach) begin
              if (bit_cnt_q != '0) err_set = 1'b1;
              shift_d   = '0;
              bit_cnt_d = '0;
              if (pix_seen_q) frame_done_d = 1'b1;
              pix_seen_d = 1'b0;
            end
          end
        end
        S_HIGH: begin
          if (high_cnt_q == HCNT_MAX) begin
            // Stuck-high line: abandon the pixel and resynchronise.
            err_set    = 1'b1;
            shift_d    = '0;
            bit_cnt_d  = '0;
            high_cnt_d = '0;
            low_cnt_d  = '0;
            state_d    = S_SYNC;
          end else if (fall) begin
            low_cnt_d  = LCNT_W'(1);
            high_cnt_d = '0;
            state_d    = S_LOW;
            if (bit_cnt_q == BCNT_W'(PIXEL_W - 1)) begin
              wr_req     = 1'b1;
              ovf_set    = fifo_full;
              pix_seen_d = 1'b1;
              shift_d    = '0;
              bit_cnt_d  = '0;
            end else begin
              shift_d   = {shift_q[PIXEL_W-3:0], bit_val};
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            high_cnt_d = high_cnt_q + 1'b1;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end
  end

  // Decoder state registers and sticky flags (clear beats a same-cycle set).
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q      <= S_SYNC;
      low_cnt_q    <= '0;
      high_cnt_q   <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      pix_seen_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      din_p_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      low_cnt_q    <= low_cnt_d;
      high_cnt_q   <= high_cnt_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      pix_seen_q   <= pix_seen_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= rx_clr ? 1'b0 : (ovf_q | ovf_set);
      err_q        <= rx_clr ? 1'b0 : (err_q | err_set);
      din_p_q      <= din_f;
    end
  end

  sync_fifo #(
    .W (PIXEL_W),
    .D (FIFO_D)
  ) u_fifo (
    .clk    (mclk),
    .rst_n  (h_reset_n),
    .wr_en  (wr_req),
    .wr_dat (wr_pix),
    .rd_en  (bus.rx_rd),
    .rd_dat (bus.rx_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bus.rx_full   = fifo_full;
  assign bus.rx_dval   = !fifo_empty;
  assign rx_frame_done = frame_done_q;
  assign rx_ovf        = ovf_q;
  assign rx_err        = err_q;

endmodule

// File: tb/tb_ws281x_rx.sv
// Directed bench for ws281x_rx: reset, framing, sync, overflow, partial/stuck errors, enable drop.
// Latency: n/a.
// Backpressure: n/a.
module tb_ws281x_rx;
  import ws281x_pkg::*;

  logic        mclk = 1'b0;
  logic        h_reset_n;
  logic        cfg_enb;
  logic [15:0] cfg_reset_period;
  logic [9:0]  cfg_bit_thresh;
  logic        rx_din;
  logic        rx_clr;
  logic        rx_frame_done, rx_ovf, rx_err;
  int          checks = 0;
  int          failures = 0;
  int          fd_cnt = 0;
  int          fd0;

  logic [23:0] ovf_pix [9] = '{24'h010203, 24'h102030, 24'hFFFFFF, 24'h000000, 24'hABCDEF,
                              24'h5A5A5A, 24'hC3C3C3, 24'h800001, 24'h7E7E7E};

  ws281x_rx_if bus ();

  ws281x_rx dut (
    .mclk             (mclk),
    .h_reset_n        (h_reset_n),
    .cfg_enb          (cfg_enb),
    .cfg_reset_period (cfg_reset_period),
    .cfg_bit_thresh   (cfg_bit_thresh),
    .rx_din           (rx_din),
    .rx_clr           (rx_clr),
    .rx_frame_done    (rx_frame_done),
    .rx_ovf           (rx_ovf),
    .rx_err           (rx_err),
    .bus              (bus)
  );

  always #5 mclk = ~mclk;

  always @(negedge mclk) if (rx_frame_done === 1'b1) fd_cnt++;

  task automatic hold(input logic lvl, input int n);
    rx_din = lvl;
    repeat (n) @(negedge mclk);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin hold(1'b1, 60); hold(1'b0, 20); end
    else   begin hold(1'b1, 20); hold(1'b0, 60); end
  endtask

  task automatic send_pix(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic pulse_rd();
    bus.rx_rd = 1'b1;
    @(negedge mclk);
    bus.rx_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    rx_clr = 1'b1;
    @(negedge mclk);
    rx_clr = 1'b0;
  endtask

  task automatic test_reset();
    h_reset_n = 1'b0; cfg_enb = 1'b1; cfg_reset_period = 16'd100; cfg_bit_thresh = 10'd40;
    rx_din = 1'b0; rx_clr = 1'b0; bus.rx_rd = 1'b0;
    repeat (3) @(negedge mclk);
    checks++; if ({bus.rx_dval, bus.rx_full, rx_frame_done, rx_ovf, rx_err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 00000",
                           {bus.rx_dval, bus.rx_full, rx_frame_done, rx_ovf, rx_err}); end
    checks++; if (bus.rx_data !== 24'h0) begin
      failures++; $display("FAIL reset_data: got %h expected 000000", bus.rx_data); end
    checks++; if (dut.state_q !== S_SYNC) begin
      failures++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, S_SYNC); end
    h_reset_n = 1'b1;
    @(negedge mclk);
  endtask

  task automatic test_basic_frame();
    fd0 = fd_cnt;
    hold(1'b0, 110);
    send_pix(24'hFF00AA);
    hold(1'b0, 110);
    checks++; if (bus.rx_data !== 24'hFF00AA) begin
      failures++; $display("FAIL basic_data: got %h expected ff00aa", bus.rx_data); end
    checks++; if (bus.rx_dval !== 1'b1) begin
      failures++; $display("FAIL basic_dval: got %b expected 1", bus.rx_dval); end
    checks++; if (fd_cnt - fd0 !== 1) begin
      failures++; $display("FAIL basic_frame_done: got %0d expected 1", fd_cnt - fd0); end
    checks++; if (rx_err !== 1'b0) begin
      failures++; $display("FAIL basic_err: got %b expected 0", rx_err); end
    pulse_rd();
    checks++; if (bus.rx_dval !== 1'b0) begin
      failures++; $display("FAIL basic_pop: got dval %b expected 0", bus.rx_dval); end
  endtask

  task automatic test_midframe_sync();
    fd0 = fd_cnt;
    cfg_enb = 1'b0;
    hold(1'b0, 3);
    cfg_enb = 1'b1;
    send_pix(24'hFFFFFF);
    checks++; if (bus.rx_dval !== 1'b0 || dut.state_q !== S_SYNC) begin
      failures++; $display("FAIL sync_nodecode: got dval %b state %0d expected 0 / %0d",
                           bus.rx_dval, dut.state_q, S_SYNC); end
    hold(1'b0, 110);
    send_pix(24'h123456);
    hold(1'b0, 110);
    checks++; if (bus.rx_data !== 24'h123456 || bus.rx_dval !== 1'b1) begin
      failures++; $display("FAIL sync_data: got %h dval %b expected 123456 / 1",
                           bus.rx_data, bus.rx_dval); end
    checks++; if (fd_cnt - fd0 !== 1) begin
      failures++; $display("FAIL sync_frame_done: got %0d expected 1", fd_cnt - fd0); end
    pulse_rd();
  endtask

  task automatic test_back_to_back_ovf();
    fd0 = fd_cnt;
    for (int i = 0; i < 8; i++) send_pix(ovf_pix[i]);
    checks++; if (bus.rx_full !== 1'b1 || rx_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_eight: got full %b ovf %b expected 1 / 0", bus.rx_full, rx_ovf); end
    send_pix(ovf_pix[8]);
    hold(1'b0, 110);
    checks++; if (rx_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_set: got %b expected 1", rx_ovf); end
    checks++; if (fd_cnt - fd0 !== 1) begin
      failures++; $display("FAIL ovf_frame_done: got %0d expected 1", fd_cnt - fd0); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.rx_data !== ovf_pix[i] || bus.rx_dval !== 1'b1) begin
        failures++; $display("FAIL ovf_read%0d: got %h dval %b expected %h / 1",
                             i, bus.rx_data, bus.rx_dval, ovf_pix[i]); end
      pulse_rd();
    end
    checks++; if (bus.rx_dval !== 1'b0) begin
      failures++; $display("FAIL ovf_drained: got dval %b expected 0", bus.rx_dval); end
    pulse_clr();
    checks++; if (rx_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_clr: got %b expected 0", rx_ovf); end
  endtask

  task automatic test_partial();
    logic [11:0] part;
    part = 12'hABC;
    fd0 = fd_cnt;
    for (int i = 11; i >= 0; i--) send_bit(part[i]);
    hold(1'b0, 110);
    checks++; if (bus.rx_dval !== 1'b0 || rx_err !== 1'b1) begin
      failures++; $display("FAIL partial_err: got dval %b err %b expected 0 / 1", bus.rx_dval, rx_err); end
    checks++; if (fd_cnt - fd0 !== 0) begin
      failures++; $display("FAIL partial_frame_done: got %0d expected 0", fd_cnt - fd0); end
    pulse_clr();
    checks++; if (rx_err !== 1'b0) begin
      failures++; $display("FAIL partial_clr: got %b expected 0", rx_err); end
    send_pix(24'h00FF0F);
    hold(1'b0, 110);
    checks++; if (bus.rx_data !== 24'h00FF0F || rx_err !== 1'b0 || fd_cnt - fd0 !== 1) begin
      failures++; $display("FAIL partial_next: got %h err %b fd %0d expected 00ff0f / 0 / 1",
                           bus.rx_data, rx_err, fd_cnt - fd0); end
    pulse_rd();
  endtask

  task automatic test_long_high_and_enb();
    hold(1'b1, 1100);
    checks++; if (rx_err !== 1'b1 || dut.state_q !== S_SYNC) begin
      failures++; $display("FAIL long_high: got err %b state %0d expected 1 / %0d",
                           rx_err, dut.state_q, S_SYNC); end
    hold(1'b0, 110);
    pulse_clr();
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    checks++; if (dut.bit_cnt_q !== 5'd10) begin
      failures++; $display("FAIL enb_bitcnt_before: got %0d expected 10", dut.bit_cnt_q); end
    cfg_enb = 1'b0;
    @(negedge mclk);
    checks++; if (dut.bit_cnt_q !== 5'd0 || dut.state_q !== S_SYNC) begin
      failures++; $display("FAIL enb_drop: got bit_cnt %0d state %0d expected 0 / %0d",
                           dut.bit_cnt_q, dut.state_q, S_SYNC); end
    checks++; if (rx_err !== 1'b0 || bus.rx_dval !== 1'b0) begin
      failures++; $display("FAIL enb_keep: got err %b dval %b expected 0 / 0", rx_err, bus.rx_dval); end
    cfg_enb = 1'b1;
    hold(1'b0, 110);
  endtask

`ifdef WS281X_RX_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic [23:0] p;
    p = 24'hA5A5A5;
    hold(1'b0, 110);
    for (int i = 23; i >= 0; i--) begin
      if (p[i]) begin hold(1'b1, 60); hold(1'b0, 8);  hold(1'b1, 2); hold(1'b0, 10); end
      else      begin hold(1'b1, 20); hold(1'b0, 25); hold(1'b1, 2); hold(1'b0, 33); end
    end
    hold(1'b0, 110);
    checks++; if (bus.rx_data !== 24'hA5A5A5 || rx_err !== 1'b0) begin
      failures++; $display("FAIL glitch_data: got %h err %b expected a5a5a5 / 0", bus.rx_data, rx_err); end
    pulse_rd();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_midframe_sync();
    test_back_to_back_ovf();
    test_partial();
    test_long_high_and_enb();
`ifdef WS281X_RX_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
